// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver with a 2-FF synchroniser, mid-bit sampling and a break guard.
// Define UART_RX_PARITY_EN to add one even-parity bit between the data bits and the stop bit.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS) + 1;
    localparam logic [TW-1:0] MID_START = TW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [TW-1:0] MID_BIT   = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t               state, state_nxt;
    logic                 rx_p0, rx_p1, rxs;
    logic [TW-1:0]        timer;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 start_smp, bit_smp;
    logic                 stop_ok, stop_ferr, stop_perr, par_bad;

    // Stage p0/p1: two-flop synchroniser, idles high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
        end
    end

    assign rxs = rx_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!rxs) state_nxt = START;
            START: if (start_smp) state_nxt = rxs ? IDLE : DATA;
            DATA: begin
                if (bit_smp && idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (bit_smp) state_nxt = STOP;
`endif
            STOP:  if (bit_smp) state_nxt = rxs ? IDLE : BREAK;
            BREAK: if (rxs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        start_smp = (state == START) && (timer == MID_START);
        bit_smp   = 1'b0;
        case (state)
`ifdef UART_RX_PARITY_EN
            DATA, PARITY, STOP: bit_smp = (timer == MID_BIT);
`else
            DATA, STOP:         bit_smp = (timer == MID_BIT);
`endif
            default:            bit_smp = 1'b0;
        endcase
        // A low stop bit wins over a parity mismatch
        stop_ferr = (state == STOP) && bit_smp && !rxs;
        stop_perr = (state == STOP) && bit_smp && rxs && par_bad;
        stop_ok   = (state == STOP) && bit_smp && rxs && !par_bad;
    end

    // Timer restarts on every state entry and every sample; it rests at 0 while waiting for the line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
            idx   <= '0;
        end else begin
            if (state_nxt != state || start_smp || bit_smp || state == IDLE || state == BREAK)
                timer <= '0;
            else
                timer <= timer + TW'(1);

            if (state == START)
                idx <= '0;
            else if (state == DATA && bit_smp)
                idx <= idx + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (state == DATA && bit_smp)
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk) begin
        if (state == PARITY && bit_smp)
            par_bit <= rxs;
    end

    assign par_bad = par_bit ^ (^shreg);
`else
    assign par_bad = 1'b0;
`endif

    // Stage p2: registered result pulses, one cycle after the mid-stop sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= stop_ok;
            frame_err <= stop_ferr;
            if (stop_ok)
                rx_data <= shreg;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_err <= 1'b0;
        else     parity_err <= stop_perr;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
